mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Stage directly downstream of the ALU.
- Consumes the ALU result, destination register, load/store/compare controls and store data.
- Performs data-memory access with a multi-cycle load latency and writes back into the 8x16 architectural register file (r7 holds compare flags).
- Provides combinational register read ports with write bypass for decode, a stall to upstream stages, and a registered writeback/forward bus.

Parameters:
- MEM_DEPTH, 256, data-memory words of 16 bits; must be a power of two.
- LOAD_LAT, 2, cycles from load acceptance to register-file write; legal range 1..7.

Ports:
- clk  input  1  clock, all state updates on its rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream presents an instruction this cycle
- isld  input  1  load: rd <= mem[aluresult]
- isst  input  1  store: mem[aluresult] <= storedata
- iswb  input  1  ALU instruction that writes rd with aluresult
- iscmp  input  1  compare: r7 <= flagval
- aluresult  input  16  ALU result or effective address
- rd  input  3  destination register
- storedata  input  16  store data
- flagval  input  16  compare flag value (0 less, 1 equal, 2 greater)
- rs1_addr  input  3  read port 1 address
- rs2_addr  input  3  read port 2 address
- rs1_data  output  16  read port 1 data
- rs2_data  output  16  read port 2 data
- stall  output  1  upstream must hold all inputs stable
- wb_valid  output  1  a register write completed at the last edge
- wb_rd  output  3  register written
- wb_data  output  16  value written
- rdvalwb  output  19  {wb_data, wb_rd}, forwarding bus

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, load counter = 0.
  - All 8 registers = 0.
  - wb_valid = 0, wb_rd = 0, wb_data = 0.
  - Data memory is not reset; it retains its contents.
- Reset asserted during LOAD_WAIT aborts the load: no register write, no wb_valid.
- Address = aluresult[log2(MEM_DEPTH)-1:0]; upper bits are ignored (wrap-around).
- FSM states: IDLE, LOAD_WAIT.
- IDLE, accepting an instruction (in_valid=1), priority isld > isst > iscmp > iswb:
  - isld: latch address and rd; counter = LOAD_LAT-1; go to LOAD_WAIT. No write this edge.
  - isst: mem[addr] <= storedata at this edge. No register write; wb_valid = 0 next cycle.
  - iscmp: r7 <= flagval. wb_valid=1, wb_rd=7, wb_data=flagval next cycle. rd and iswb are ignored.
  - iswb: reg[rd] <= aluresult. wb_valid=1, wb_rd=rd, wb_data=aluresult next cycle.
  - No control set, or in_valid=0: no write; wb_valid = 0.
- LOAD_WAIT:
  - While counter != 0, decrement it.
  - When counter = 0: reg[latched rd] <= mem[latched addr]; wb_* registered with that value; go to IDLE.
  - Inputs are ignored in this state; upstream holds them because stall is high.
- stall = (state==LOAD_WAIT and counter != 0) or (state==IDLE and in_valid and isld and LOAD_LAT > 1).
  - stall is combinational.
  - Net effect: a load accepted at edge T writes at edge T+LOAD_LAT.
  - stall is high for LOAD_LAT-1 cycles after acceptance plus the accept cycle itself when LOAD_LAT > 1.
  - Upstream may present the next instruction in the cycle the load completes; it is accepted at the following edge in IDLE.
- Outside these rules, wb_valid deasserts after one cycle (pulse per write).
- Read ports:
  - rs*_data = reg[rs*_addr], combinational.
  - Bypass: if a register write to the same address occurs at the coming edge (iswb/iscmp in IDLE, or load completion), return the write value instead.
  - No hardwired zero register; r0..r7 are all writable.
- Store followed by a load to the same address returns the stored data (the write completes before the read).
- isld and isst both set is illegal; it is treated as a load.
- Widths: all data is 16-bit; no sign extension in this stage.

Test Plan:
- Reset with all registers loaded non-zero; pull rst_n low mid-cycle -> all regs 0, wb_valid=0, stall=0 immediately, without waiting for a clock edge.
- iswb rd=3 aluresult=0x1234 -> next cycle wb_valid=1, wb_rd=3, wb_data=0x1234, rdvalwb=0x91A3; rs1_addr=3 returns 0x1234 in the same cycle via bypass.
- Store 0xBEEF at aluresult=0x0105 (MEM_DEPTH=256), then load rd=2 from 0x0005 with LOAD_LAT=2 -> stall high for 1 cycle; r2=0xBEEF written 2 edges after acceptance; wb_rd=2.
- iscmp flagval=2 with rd=4 and iswb=1 -> r7=2, r4 unchanged, wb_rd=7.
- Load in flight with an ALU op held at the input -> the ALU op is not committed until the load completes; both writes occur in order with no lost wb_valid pulse.
- Assert rst_n low during LOAD_WAIT -> target register stays 0, state IDLE, no wb_valid pulse after release.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: data-memory access with a multi-cycle load,
// an 8x16 register file (r7 receives compare flags), bypassed read ports,
// an upstream stall and a registered writeback/forward bus.
module mem_wb_stage #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned LOAD_LAT  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        isld,
    input  logic        isst,
    input  logic        iswb,
    input  logic        iscmp,
    input  logic [15:0] aluresult,
    input  logic [2:0]  rd,
    input  logic [15:0] storedata,
    input  logic [15:0] flagval,
    input  logic [2:0]  rs1_addr,
    input  logic [2:0]  rs2_addr,
    output logic [15:0] rs1_data,
    output logic [15:0] rs2_data,
    output logic        stall,
    output logic        wb_valid,
    output logic [2:0]  wb_rd,
    output logic [15:0] wb_data,
    output logic [18:0] rdvalwb
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);
    localparam logic [2:0] LatInit = 3'(LOAD_LAT - 1);
    localparam bit MultiCycle = (LOAD_LAT > 1);

    typedef enum logic [0:0] {StIdle, StLoadWait} state_e;

    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [AW-1:0]   ld_addr_q, ld_addr_d;
    logic [2:0]      ld_rd_q, ld_rd_d;

    logic [15:0]     regs_q [8];
    logic [15:0]     mem [MEM_DEPTH];

    logic            wb_valid_q;
    logic [2:0]      wb_rd_q;
    logic [15:0]     wb_data_q;

    logic [AW-1:0]   addr;
    logic            accept;
    logic            ld_done;
    logic            wr_en;
    logic [2:0]      wr_rd;
    logic [15:0]     wr_data;
    logic            mem_we;

    // Upper address bits wrap and are deliberately dropped.
    assign addr = aluresult[AW-1:0];
    generate
        if (AW < 16) begin : g_unused_addr
            logic unused_addr_hi;
            assign unused_addr_hi = ^aluresult[15:AW];
        end
    endgenerate

    assign accept  = (state_q == StIdle) && in_valid;
    assign ld_done = (state_q == StLoadWait) && (cnt_q == 3'd0);

    // State register: FSM, load countdown and latched load target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 3'd0;
            ld_addr_q <= '0;
            ld_rd_q   <= 3'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ld_addr_q <= ld_addr_d;
            ld_rd_q   <= ld_rd_d;
        end
    end

    // Next-state logic: a load parks the stage until its countdown expires.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ld_addr_d = ld_addr_q;
        ld_rd_d   = ld_rd_q;
        unique case (state_q)
            StIdle: begin
                if (accept && isld) begin
                    state_d   = StLoadWait;
                    cnt_d     = LatInit;
                    ld_addr_d = addr;
                    ld_rd_d   = rd;
                end
            end
            StLoadWait: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode: the register write due at the coming edge, store enable, stall.
    always_comb begin
        wr_en   = 1'b0;
        wr_rd   = 3'd0;
        wr_data = 16'd0;
        mem_we  = 1'b0;
        if (ld_done) begin
            wr_en   = 1'b1;
            wr_rd   = ld_rd_q;
            wr_data = mem[ld_addr_q];
        end else if (accept && !isld) begin
            if (isst) begin
                mem_we = 1'b1;
            end else if (iscmp) begin
                wr_en   = 1'b1;
                wr_rd   = 3'd7;
                wr_data = flagval;
            end else if (iswb) begin
                wr_en   = 1'b1;
                wr_rd   = rd;
                wr_data = aluresult;
            end
        end
        stall = ((state_q == StLoadWait) && (cnt_q != 3'd0)) ||
                (accept && isld && MultiCycle);
    end

    // Data memory: write-only at the edge, never reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr] <= storedata;
        end
    end

    // Architectural register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 16'd0;
            end
        end else if (wr_en) begin
            regs_q[wr_rd] <= wr_data;
        end
    end

    // Writeback bus: one-cycle valid pulse per completed register write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 3'd0;
            wb_data_q  <= 16'd0;
        end else begin
            wb_valid_q <= wr_en;
            if (wr_en) begin
                wb_rd_q   <= wr_rd;
                wb_data_q <= wr_data;
            end
        end
    end

    // Read ports forward the value being written at the coming edge.
    assign rs1_data = (wr_en && (wr_rd == rs1_addr)) ? wr_data : regs_q[rs1_addr];
    assign rs2_data = (wr_en && (wr_rd == rs2_addr)) ? wr_data : regs_q[rs2_addr];

    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign rdvalwb  = {wb_data_q, wb_rd_q};

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    localparam int MEM_DEPTH = 256;
    localparam int LOAD_LAT  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, isld, isst, iswb, iscmp;
    logic [15:0] aluresult, storedata, flagval;
    logic [2:0]  rd, rs1_addr, rs2_addr;
    logic [15:0] rs1_data, rs2_data, wb_data;
    logic        stall, wb_valid;
    logic [2:0]  wb_rd;
    logic [18:0] rdvalwb;

    always #5 clk = ~clk;

    mem_wb_stage #(.MEM_DEPTH(MEM_DEPTH), .LOAD_LAT(LOAD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .isld(isld), .isst(isst),
        .iswb(iswb), .iscmp(iscmp), .aluresult(aluresult), .rd(rd),
        .storedata(storedata), .flagval(flagval), .rs1_addr(rs1_addr),
        .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .rdvalwb(rdvalwb)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: architectural state plus the edge number a pending load lands on.
    logic [15:0] m_regs [8];
    logic [15:0] m_mem [MEM_DEPTH];
    bit          m_busy;
    int          edge_no, done_edge;
    logic [2:0]  pend_rd;
    logic [7:0]  pend_addr;
    logic        exp_wbv;
    logic [2:0]  exp_wbrd;
    logic [15:0] exp_wbdata;

    function automatic void coming_write(output logic en, output logic [2:0] r,
                                         output logic [15:0] d);
        en = 1'b0; r = 3'd0; d = 16'd0;
        if (m_busy) begin
            if (edge_no + 1 == done_edge) begin
                en = 1'b1; r = pend_rd; d = m_mem[pend_addr];
            end
        end else if (in_valid && !isld && !isst) begin
            if (iscmp) begin
                en = 1'b1; r = 3'd7; d = flagval;
            end else if (iswb) begin
                en = 1'b1; r = rd; d = aluresult;
            end
        end
    endfunction

    function automatic bit exp_stall();
        if (m_busy) return (edge_no + 1 < done_edge);
        return in_valid && isld && (LOAD_LAT > 1);
    endfunction

    function automatic logic [15:0] exp_read(input logic [2:0] a);
        logic en; logic [2:0] r; logic [15:0] d;
        coming_write(en, r, d);
        if (en && r == a) return d;
        return m_regs[a];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'd0;
        m_busy = 0;
        exp_wbv = 1'b0; exp_wbrd = 3'd0; exp_wbdata = 16'd0;
    endfunction

    // Advance one clock edge, updating the model from the pre-edge inputs.
    task automatic step();
        logic en; logic [2:0] r; logic [15:0] d;
        bit st, ld;
        coming_write(en, r, d);
        st = !m_busy && in_valid && !isld && isst;
        ld = !m_busy && in_valid && isld;
        if (m_busy && edge_no + 1 == done_edge) m_busy = 0;
        if (st) m_mem[aluresult[7:0]] = storedata;
        if (ld) begin
            m_busy = 1; done_edge = edge_no + 1 + LOAD_LAT;
            pend_rd = rd; pend_addr = aluresult[7:0];
        end
        @(posedge clk);
        #1;
        edge_no++;
        if (en) begin
            m_regs[r] = d; exp_wbrd = r; exp_wbdata = d;
        end
        exp_wbv = en;
    endtask

    task automatic idle_inputs();
        in_valid = 0; isld = 0; isst = 0; iswb = 0; iscmp = 0;
        aluresult = 0; rd = 0; storedata = 0; flagval = 0;
    endtask

    task automatic set_op(input bit l, input bit s, input bit w, input bit c,
                          input logic [15:0] a, input logic [2:0] r,
                          input logic [15:0] sd, input logic [15:0] fv);
        in_valid = 1; isld = l; isst = s; iswb = w; iscmp = c;
        aluresult = a; rd = r; storedata = sd; flagval = fv;
    endtask

    task automatic test_fill_mem();
        for (int a = 0; a < MEM_DEPTH; a++) begin
            set_op(0, 1, 0, 0, {8'($urandom), 8'(a)}, 3'($urandom), 16'($urandom), 0);
            step();
            n_tests++;
            if (wb_valid !== 1'b0) begin
                n_fail++; $display("FAIL store_no_wb: got %b want 0", wb_valid);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) begin
            set_op(0, 0, 1, 0, 16'h1111 * 16'(i) + 16'h0101, 3'(i), 0, 0);
            step();
        end
        set_op(1, 0, 0, 0, 16'h0010, 3'd5, 0, 0);
        step();
        idle_inputs();
        #1;
        n_tests++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL reset_pre_stall: got %b want 1", stall);
        end
        rst_n = 0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            rs1_addr = 3'(i); rs2_addr = 3'(i + 4);
            #1;
            n_tests++;
            if (rs1_data !== 16'd0 || rs2_data !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_regs r%0d/r%0d: got %h/%h want 0", i, i + 4,
                         rs1_data, rs2_data);
            end
        end
        n_tests++;
        if (wb_valid !== 1'b0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_outs: wb_valid %b stall %b want 0 0", wb_valid, stall);
        end
        rst_n = 1;
        for (int i = 0; i <= LOAD_LAT; i++) begin
            step();
            n_tests++;
            if (wb_valid !== 1'b0) begin
                n_fail++; $display("FAIL reset_no_wb: got %b want 0", wb_valid);
            end
        end
    endtask

    task automatic test_alu_write();
        set_op(0, 0, 1, 0, 16'h1234, 3'd3, 0, 0);
        rs1_addr = 3'd3;
        #1;
        n_tests++;
        if (rs1_data !== 16'h1234) begin
            n_fail++; $display("FAIL alu_bypass: got %h want 1234", rs1_data);
        end
        step();
        idle_inputs();
        n_tests++;
        if (wb_valid !== 1'b1 || wb_rd !== 3'd3 || wb_data !== 16'h1234 || rdvalwb !== 19'h091A3)
        begin
            n_fail++;
            $display("FAIL alu_wb: got v%b rd%0d %h bus %h want v1 rd3 1234 bus 091a3",
                     wb_valid, wb_rd, wb_data, rdvalwb);
        end
        step();
        n_tests++;
        if (wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL alu_pulse: got %b want 0", wb_valid);
        end
    endtask

    task automatic test_store_load();
        set_op(0, 1, 0, 0, 16'h0105, 3'd1, 16'hBEEF, 0);
        step();
        set_op(1, 0, 0, 0, 16'h0005, 3'd2, 0, 0);
        #1;
        n_tests++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL load_accept_stall: got %b want 1", stall);
        end
        step();
        n_tests++;
        if (stall !== 1'b1 || wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL load_wait: stall %b wb %b want 1 0", stall, wb_valid);
        end
        step();
        rs2_addr = 3'd2;
        #1;
        n_tests++;
        if (stall !== 1'b0 || wb_valid !== 1'b0 || rs2_data !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL load_last: stall %b wb %b rs2 %h want 0 0 beef", stall, wb_valid, rs2_data);
        end
        step();
        idle_inputs();
        n_tests++;
        if (wb_valid !== 1'b1 || wb_rd !== 3'd2 || wb_data !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL load_wb: got v%b rd%0d %h want v1 rd2 beef", wb_valid, wb_rd, wb_data);
        end
    endtask

    task automatic test_compare();
        logic [15:0] r4_before;
        r4_before = m_regs[4];
        set_op(0, 0, 1, 1, 16'h5555, 3'd4, 0, 16'd2);
        step();
        idle_inputs();
        rs1_addr = 3'd7; rs2_addr = 3'd4;
        #1;
        n_tests++;
        if (wb_valid !== 1'b1 || wb_rd !== 3'd7 || wb_data !== 16'd2) begin
            n_fail++; $display("FAIL cmp_wb: got v%b rd%0d %h want v1 rd7 0002",
                               wb_valid, wb_rd, wb_data);
        end
        n_tests++;
        if (rs1_data !== 16'd2 || rs2_data !== r4_before) begin
            n_fail++; $display("FAIL cmp_regs: r7 %h r4 %h want 0002 %h", rs1_data, rs2_data,
                               r4_before);
        end
    endtask

    task automatic test_load_then_alu();
        int pulses;
        logic [15:0] ld_val;
        pulses = 0;
        ld_val = m_mem[8'h42];
        set_op(1, 0, 0, 0, 16'h0042, 3'd6, 0, 0);
        for (int cyc = 0; cyc < 12 && pulses < 2; cyc++) begin
            if (m_busy && !exp_stall()) set_op(0, 0, 1, 0, 16'hA5A5, 3'd6, 0, 0);
            #1;
            step();
            if (wb_valid === 1'b1) begin
                pulses++;
                n_tests++;
                if (pulses == 1 && wb_data !== ld_val) begin
                    n_fail++; $display("FAIL order_first: got %h want %h", wb_data, ld_val);
                end
                if (pulses == 2 && wb_data !== 16'hA5A5) begin
                    n_fail++; $display("FAIL order_second: got %h want a5a5", wb_data);
                end
                if (pulses == 2) idle_inputs();
            end
        end
        idle_inputs();
        n_tests++;
        if (pulses != 2) begin
            n_fail++; $display("FAIL order_pulses: got %0d want 2", pulses);
        end
        rs1_addr = 3'd6;
        #1;
        n_tests++;
        if (rs1_data !== 16'hA5A5) begin
            n_fail++; $display("FAIL order_final: got %h want a5a5", rs1_data);
        end
    endtask

    task automatic test_reset_during_load();
        set_op(1, 0, 0, 0, 16'h0077, 3'd5, 0, 0);
        step();
        #2;
        rst_n = 0;
        model_reset();
        idle_inputs();
        #2;
        rst_n = 1;
        for (int i = 0; i <= LOAD_LAT + 1; i++) begin
            step();
            n_tests++;
            if (wb_valid !== 1'b0 || stall !== 1'b0) begin
                n_fail++; $display("FAIL abort_load: wb %b stall %b want 0 0", wb_valid, stall);
            end
        end
        rs1_addr = 3'd5;
        #1;
        n_tests++;
        if (rs1_data !== 16'd0) begin
            n_fail++; $display("FAIL abort_reg: got %h want 0", rs1_data);
        end
    endtask

    task automatic test_random();
        bit held;
        held = 0;
        for (int it = 0; it < 600; it++) begin
            if (!held) begin
                if ($urandom_range(0, 9) < 8) begin
                    set_op(1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 3) == 0),
                           1'($urandom), 1'($urandom_range(0, 3) == 0), 16'($urandom),
                           3'($urandom), 16'($urandom), 16'($urandom_range(0, 2)));
                end else begin
                    idle_inputs();
                end
            end
            rs1_addr = 3'($urandom); rs2_addr = 3'($urandom);
            #1;
            n_tests++;
            if (stall !== exp_stall()) begin
                n_fail++; $display("FAIL rnd_stall it%0d: got %b want %b", it, stall, exp_stall());
            end
            n_tests++;
            if (rs1_data !== exp_read(rs1_addr) || rs2_data !== exp_read(rs2_addr)) begin
                n_fail++;
                $display("FAIL rnd_read it%0d: got %h/%h want %h/%h", it, rs1_data, rs2_data,
                         exp_read(rs1_addr), exp_read(rs2_addr));
            end
            held = exp_stall();
            step();
            n_tests++;
            if (wb_valid !== exp_wbv ||
                (exp_wbv && (wb_rd !== exp_wbrd || wb_data !== exp_wbdata))) begin
                n_fail++;
                $display("FAIL rnd_wb it%0d: got v%b rd%0d %h want v%b rd%0d %h", it, wb_valid,
                         wb_rd, wb_data, exp_wbv, exp_wbrd, exp_wbdata);
            end
        end
        idle_inputs();
        while (m_busy) step();
        for (int i = 0; i < 8; i++) begin
            rs1_addr = 3'(i);
            #1;
            n_tests++;
            if (rs1_data !== m_regs[i]) begin
                n_fail++; $display("FAIL rnd_final r%0d: got %h want %h", i, rs1_data, m_regs[i]);
            end
        end
    endtask

    initial begin
        idle_inputs();
        rs1_addr = 0; rs2_addr = 0;
        rst_n = 0;
        model_reset();
        edge_no = 0; done_edge = 0; pend_rd = 0; pend_addr = 0;
        for (int i = 0; i < MEM_DEPTH; i++) m_mem[i] = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        test_fill_mem();
        test_reset();
        test_alu_write();
        test_store_load();
        test_compare();
        test_load_then_alu();
        test_reset_during_load();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
